// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: major opcodes, ALU op codes and the issue FSM states.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_FENCE  = 7'h0F;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_BNE  = 4'b1111;
    localparam logic [3:0] ALU_BLT  = 4'b1100;
    localparam logic [3:0] ALU_BGE  = 4'b1011;
    localparam logic [3:0] ALU_BLTU = 4'b1010;
    localparam logic [3:0] ALU_BGEU = 4'b1001;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_BWAIT = 1'b1
    } state_t;

endpackage

// File: rtl/ex_decode_if.sv
// Issue-stage bus: front-end handshake, ALU operand outputs, result/branch sideband.
interface ex_decode_if;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        i_zero;
    logic [31:0] o_alu_a;
    logic [31:0] o_alu_b;
    logic [3:0]  o_alu_op;
    logic        o_alu_valid;
    logic        o_res_valid;
    logic [4:0]  o_res_rd;
    logic        o_res_we;
    logic        o_res_ls;
    logic        o_br_valid;
    logic        o_br_taken;
    logic [31:0] o_br_target;
    logic        o_illegal;

    // Front end / ALU side driving instructions and the zero flag
    modport master (
        output i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_zero,
        input  o_ready, o_alu_a, o_alu_b, o_alu_op, o_alu_valid, o_res_valid,
               o_res_rd, o_res_we, o_res_ls, o_br_valid, o_br_taken,
               o_br_target, o_illegal
    );

    // Decode stage side
    modport slave (
        input  i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_zero,
        output o_ready, o_alu_a, o_alu_b, o_alu_op, o_alu_valid, o_res_valid,
               o_res_rd, o_res_we, o_res_ls, o_br_valid, o_br_taken,
               o_br_target, o_illegal
    );
endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction (I/S/B/U/J), all sign-extended to 32 bits.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:7] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u,
    output logic [31:0] imm_j
);
    assign imm_i = {{21{instr[31]}}, instr[30:20]};
    assign imm_s = {{21{instr[31]}}, instr[30:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
endmodule

// File: rtl/ex_decode.sv
// Issue stage: decodes RV32I into ALU op/operands, delays writeback and branch
// tags to line up with the ALU result and zero flag, and stalls on control flow.
module ex_decode
    import rv32i_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int BR_STALL = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    ex_decode_if.slave   bus
);
    localparam int CNT_W = $clog2(BR_STALL + 1);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_b5;
    logic [4:0]      rd;
    logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0]     jalr_sum;
    logic [XLEN-1:0] dec_a, dec_b, dec_target;
    logic [3:0]      dec_op;
    logic            dec_alu_valid, dec_illegal, dec_we, dec_ls, dec_branch, dec_jump;
    logic            accept, ready;

    state_t          state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [31:0] alu_a_reg, alu_b_reg;
    logic [3:0]  alu_op_reg;
    logic        alu_valid_reg, illegal_reg;
    logic        s1_valid_reg, s1_we_reg, s1_ls_reg, s1_ctrl_reg, s1_jump_reg;
    logic [4:0]  s1_rd_reg;
    logic [31:0] s1_target_reg;
    logic        res_valid_reg, res_we_reg, res_ls_reg;
    logic [4:0]  res_rd_reg;
    logic        s2_ctrl_reg, s2_jump_reg;
    logic [31:0] s2_target_reg;
    logic        br_valid_reg, br_jump_reg;
    logic [31:0] br_target_reg;

    assign opcode    = bus.i_instr[6:0];
    assign rd        = bus.i_instr[11:7];
    assign funct3    = bus.i_instr[14:12];
    assign funct7_b5 = bus.i_instr[30];
    assign jalr_sum  = bus.i_rs1_data + imm_i;
    assign accept    = bus.i_valid & ready;

    imm_gen u_imm_gen (
        .instr (bus.i_instr[31:7]),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    // Instruction decode: ALU op, operands and sideband tags for the presented word
    always_comb begin
        dec_a         = bus.i_rs1_data;
        dec_b         = bus.i_rs2_data;
        dec_op        = ALU_ADD;
        dec_alu_valid = 1'b1;
        dec_illegal   = 1'b0;
        dec_we        = 1'b0;
        dec_ls        = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_target    = bus.i_pc + imm_b;
        case (opcode)
            OPC_OP: begin
                dec_op = {funct7_b5, funct3};
                dec_we = 1'b1;
            end
            OPC_OPIMM: begin
                // Only the shift-right group uses bit 30 to pick SRA over SRL
                dec_op = {(funct3 == 3'b101) & funct7_b5, funct3};
                dec_b  = imm_i;
                dec_we = 1'b1;
            end
            OPC_LUI: begin
                dec_a  = '0;
                dec_b  = imm_u;
                dec_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec_a  = bus.i_pc;
                dec_b  = imm_u;
                dec_we = 1'b1;
            end
            OPC_LOAD: begin
                dec_b  = imm_i;
                dec_ls = 1'b1;
                dec_we = 1'b1;
            end
            OPC_STORE: begin
                dec_b  = imm_s;
                dec_ls = 1'b1;
            end
            OPC_BRANCH: begin
                dec_branch = 1'b1;
                // Ops chosen so the ALU zero flag means "branch taken"
                case (funct3)
                    3'b000:  dec_op = ALU_SUB;
                    3'b001:  dec_op = ALU_BNE;
                    3'b100:  dec_op = ALU_BLT;
                    3'b101:  dec_op = ALU_BGE;
                    3'b110:  dec_op = ALU_BLTU;
                    3'b111:  dec_op = ALU_BGEU;
                    default: begin
                        dec_branch    = 1'b0;
                        dec_alu_valid = 1'b0;
                        dec_illegal   = 1'b1;
                    end
                endcase
            end
            OPC_JAL: begin
                dec_a      = bus.i_pc;
                dec_b      = 32'd4;
                dec_we     = 1'b1;
                dec_jump   = 1'b1;
                dec_target = bus.i_pc + imm_j;
            end
            OPC_JALR: begin
                dec_a      = bus.i_pc;
                dec_b      = 32'd4;
                dec_we     = 1'b1;
                dec_jump   = 1'b1;
                dec_target = {jalr_sum[31:1], 1'b0};
            end
            OPC_FENCE: begin
                dec_alu_valid = 1'b0;
            end
            default: begin
                // SYSTEM and anything unrecognised
                dec_alu_valid = 1'b0;
                dec_illegal   = 1'b1;
            end
        endcase
        if (rd == 5'd0) begin
            dec_we = 1'b0;
        end
    end

    // ALU input registers: load only on a real operation, otherwise hold
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
            alu_op_reg <= ALU_ADD;
        end else if (accept && dec_alu_valid) begin
            alu_a_reg  <= dec_a;
            alu_b_reg  <= dec_b;
            alu_op_reg <= dec_op;
        end
    end

    // Sideband delay line: stage 1 aligns with ALU inputs, stage 2 with result, stage 3 with zero flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            alu_valid_reg <= 1'b0;
            illegal_reg   <= 1'b0;
            s1_valid_reg  <= 1'b0;
            s1_we_reg     <= 1'b0;
            s1_ls_reg     <= 1'b0;
            s1_ctrl_reg   <= 1'b0;
            s1_jump_reg   <= 1'b0;
            s1_rd_reg     <= '0;
            s1_target_reg <= '0;
            res_valid_reg <= 1'b0;
            res_we_reg    <= 1'b0;
            res_ls_reg    <= 1'b0;
            res_rd_reg    <= '0;
            s2_ctrl_reg   <= 1'b0;
            s2_jump_reg   <= 1'b0;
            s2_target_reg <= '0;
            br_valid_reg  <= 1'b0;
            br_jump_reg   <= 1'b0;
            br_target_reg <= '0;
        end else begin
            alu_valid_reg <= accept & dec_alu_valid;
            illegal_reg   <= accept & dec_illegal;
            s1_valid_reg  <= accept & dec_alu_valid;
            s1_we_reg     <= dec_we;
            s1_ls_reg     <= dec_ls;
            s1_ctrl_reg   <= accept & (dec_branch | dec_jump);
            s1_jump_reg   <= dec_jump;
            s1_rd_reg     <= rd;
            s1_target_reg <= dec_target;
            res_valid_reg <= s1_valid_reg;
            res_we_reg    <= s1_valid_reg & s1_we_reg;
            res_ls_reg    <= s1_valid_reg & s1_ls_reg;
            res_rd_reg    <= s1_rd_reg;
            s2_ctrl_reg   <= s1_ctrl_reg;
            s2_jump_reg   <= s1_jump_reg;
            s2_target_reg <= s1_target_reg;
            br_valid_reg  <= s2_ctrl_reg;
            br_jump_reg   <= s2_ctrl_reg & s2_jump_reg;
            if (s2_ctrl_reg) begin
                br_target_reg <= s2_target_reg;
            end
        end
    end

    // FSM state and stall counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // FSM next state: a control transfer stalls for BR_STALL cycles
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (accept && (dec_branch || dec_jump)) begin
                    state_next = ST_BWAIT;
                    cnt_next   = CNT_W'(BR_STALL);
                end
            end
            ST_BWAIT: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // FSM outputs: ready only in RUN, and forced low while reset is held
    always_comb begin
        ready = (state_reg == ST_RUN) & ~i_rst;
    end

    assign bus.o_ready     = ready;
    assign bus.o_alu_a     = alu_a_reg;
    assign bus.o_alu_b     = alu_b_reg;
    assign bus.o_alu_op    = alu_op_reg;
    assign bus.o_alu_valid = alu_valid_reg;
    assign bus.o_illegal   = illegal_reg;
    assign bus.o_res_valid = res_valid_reg;
    assign bus.o_res_rd    = res_rd_reg;
    assign bus.o_res_we    = res_we_reg;
    assign bus.o_res_ls    = res_ls_reg;
    assign bus.o_br_valid  = br_valid_reg;
    assign bus.o_br_taken  = br_valid_reg & (br_jump_reg | bus.i_zero);
    assign bus.o_br_target = br_target_reg;
endmodule

// File: tb/tb_ex_decode.sv
// Self-checking bench for ex_decode: directed scenarios plus a randomized stream
// compared against an instruction-level reference model.
module tb_ex_decode;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ex_decode_if bus ();

    ex_decode #(.XLEN(32), .BR_STALL(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        alu_v;
        logic        ill;
        logic        we;
        logic        ls;
        logic [4:0]  rd;
    } exp_t;

    // Instruction-level reference: what the ALU and writeback should see
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t        e;
        logic [2:0]  f3;
        logic [31:0] imm_i, imm_s;
        f3    = ins[14:12];
        imm_i = 32'($signed(ins[31:20]));
        imm_s = 32'($signed({ins[31:25], ins[11:7]}));
        e       = '0;
        e.rd    = ins[11:7];
        e.alu_v = 1'b1;
        e.a     = rs1;
        case (ins[6:0])
            7'h33: begin e.b = rs2;   e.op = {ins[30], f3};                  e.we = 1'b1; end
            7'h13: begin e.b = imm_i; e.op = {(f3 == 3'd5) && ins[30], f3};  e.we = 1'b1; end
            7'h37: begin e.a = 32'd0; e.b = ins & 32'hFFFF_F000;             e.we = 1'b1; end
            7'h17: begin e.a = pc;    e.b = ins & 32'hFFFF_F000;             e.we = 1'b1; end
            7'h03: begin e.b = imm_i; e.ls = 1'b1;                           e.we = 1'b1; end
            7'h23: begin e.b = imm_s; e.ls = 1'b1; end
            7'h0F: begin e.alu_v = 1'b0; end
            default: begin e.alu_v = 1'b0; e.ill = 1'b1; end
        endcase
        if (e.rd == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, int opc);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'(opc)};
    endfunction

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int opc);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(opc)};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [12:0] v;
        v = 13'(imm);
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [112:0] all_outs();
        return {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_alu_valid, bus.o_res_valid,
                bus.o_res_rd, bus.o_res_we, bus.o_res_ls, bus.o_br_valid, bus.o_br_taken,
                bus.o_br_target, bus.o_illegal, bus.o_ready};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        bus.i_valid    = 1'b1;
        bus.i_instr    = ins;
        bus.i_pc       = pc;
        bus.i_rs1_data = r1;
        bus.i_rs2_data = r2;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++; if (all_outs() !== '0) begin errors++; $display("FAIL reset_outs: got %h expected 0", all_outs()); end
        step();
        @(negedge clk) rst = 1'b0;
        #1;
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.o_ready); end
        $display("reset: released, ready=%b", bus.o_ready);
        step();
    endtask

    task automatic test_addi();
        issue(enc_i(-1, 1, 0, 5, 7'h13), 32'h0, 32'd5, 32'd0);
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL addi_ready: got %b expected 1", bus.o_ready); end
        step();
        bus.i_valid = 1'b0;
        checks++; if ({bus.o_alu_op, bus.o_alu_a, bus.o_alu_b, bus.o_alu_valid} !== {4'b0000, 32'd5, 32'hFFFF_FFFF, 1'b1})
            begin errors++; $display("FAIL addi_alu: got op=%h a=%h b=%h v=%b expected op=0 a=5 b=ffffffff v=1", bus.o_alu_op, bus.o_alu_a, bus.o_alu_b, bus.o_alu_valid); end
        step();
        checks++; if ({bus.o_res_valid, bus.o_res_rd, bus.o_res_we, bus.o_res_ls} !== {1'b1, 5'd5, 1'b1, 1'b0})
            begin errors++; $display("FAIL addi_res: got v=%b rd=%0d we=%b ls=%b expected 1 5 1 0", bus.o_res_valid, bus.o_res_rd, bus.o_res_we, bus.o_res_ls); end
        checks++; if (bus.o_alu_valid !== 1'b0) begin errors++; $display("FAIL addi_idle: got alu_valid=%b expected 0", bus.o_alu_valid); end
        step();
        checks++; if ({bus.o_br_valid, bus.o_res_valid} !== 2'b00) begin errors++; $display("FAIL addi_nobr: got br=%b res=%b expected 0 0", bus.o_br_valid, bus.o_res_valid); end
        checks++; if ({bus.o_alu_a, bus.o_alu_b} !== {32'd5, 32'hFFFF_FFFF}) begin errors++; $display("FAIL addi_hold: got a=%h b=%h expected 5 ffffffff", bus.o_alu_a, bus.o_alu_b); end
        $display("addi: op=%h a=%h b=%h", bus.o_alu_op, bus.o_alu_a, bus.o_alu_b);
    endtask

    task automatic test_back_to_back();
        issue(enc_r(7'h20, 6, 4, 5, 3, 7'h33), 32'h0, 32'h8000_0000, 32'd4);
        step();
        checks++; if ({bus.o_alu_op, bus.o_alu_valid, bus.o_ready} !== {4'b1101, 1'b1, 1'b1})
            begin errors++; $display("FAIL b2b_sra: got op=%h v=%b rdy=%b expected d 1 1", bus.o_alu_op, bus.o_alu_valid, bus.o_ready); end
        issue(enc_r(7'h20, 2, 1, 0, 7, 7'h33), 32'h0, 32'd9, 32'd3);
        step();
        bus.i_valid = 1'b0;
        checks++; if ({bus.o_alu_op, bus.o_alu_a, bus.o_alu_b, bus.o_alu_valid, bus.o_ready} !== {4'b1000, 32'd9, 32'd3, 1'b1, 1'b1})
            begin errors++; $display("FAIL b2b_sub: got op=%h a=%h b=%h v=%b rdy=%b expected 8 9 3 1 1", bus.o_alu_op, bus.o_alu_a, bus.o_alu_b, bus.o_alu_valid, bus.o_ready); end
        checks++; if ({bus.o_res_valid, bus.o_res_rd} !== {1'b1, 5'd3}) begin errors++; $display("FAIL b2b_res: got v=%b rd=%0d expected 1 3", bus.o_res_valid, bus.o_res_rd); end
        $display("back_to_back: sra then sub issued");
        step();
        step();
    endtask

    task automatic test_branch(input logic [31:0] rs2v, input logic zero, input logic exp_taken);
        issue(enc_b(16, 2, 1, 0), 32'h100, 32'd7, rs2v);
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL beq_ready_t: got %b expected 1", bus.o_ready); end
        step();
        issue(enc_i(1, 1, 0, 9, 7'h13), 32'h104, 32'd1, 32'd1);  // must be held off by the stall
        checks++; if ({bus.o_alu_op, bus.o_alu_a, bus.o_alu_b, bus.o_ready} !== {4'b1000, 32'd7, rs2v, 1'b0})
            begin errors++; $display("FAIL beq_t1: got op=%h a=%h b=%h rdy=%b expected 8 7 %h 0", bus.o_alu_op, bus.o_alu_a, bus.o_alu_b, bus.o_ready, rs2v); end
        step();
        checks++; if ({bus.o_ready, bus.o_alu_valid, bus.o_res_valid, bus.o_res_we} !== 4'b0010)
            begin errors++; $display("FAIL beq_t2: got rdy=%b av=%b rv=%b we=%b expected 0 0 1 0", bus.o_ready, bus.o_alu_valid, bus.o_res_valid, bus.o_res_we); end
        bus.i_valid = 1'b0;
        bus.i_zero  = zero;
        step();
        checks++; if ({bus.o_br_valid, bus.o_br_taken, bus.o_br_target, bus.o_ready} !== {1'b1, exp_taken, 32'h110, 1'b0})
            begin errors++; $display("FAIL beq_t3: got bv=%b tk=%b tgt=%h rdy=%b expected 1 %b 110 0", bus.o_br_valid, bus.o_br_taken, bus.o_br_target, bus.o_ready, exp_taken); end
        step();
        bus.i_zero = 1'b0;
        checks++; if ({bus.o_ready, bus.o_br_valid, bus.o_alu_valid} !== 3'b100)
            begin errors++; $display("FAIL beq_t4: got rdy=%b bv=%b av=%b expected 1 0 0", bus.o_ready, bus.o_br_valid, bus.o_alu_valid); end
        $display("beq: rs2=%0d zero=%b taken=%b", rs2v, zero, exp_taken);
    endtask

    task automatic test_jalr();
        bus.i_zero = 1'b0;
        issue(enc_i(4, 1, 0, 1, 7'h67), 32'h40, 32'h203, 32'd0);
        step();
        bus.i_valid = 1'b0;
        checks++; if ({bus.o_alu_op, bus.o_alu_a, bus.o_alu_b, bus.o_alu_valid, bus.o_ready} !== {4'b0000, 32'h40, 32'd4, 1'b1, 1'b0})
            begin errors++; $display("FAIL jalr_alu: got op=%h a=%h b=%h v=%b rdy=%b expected 0 40 4 1 0", bus.o_alu_op, bus.o_alu_a, bus.o_alu_b, bus.o_alu_valid, bus.o_ready); end
        step();
        checks++; if ({bus.o_res_valid, bus.o_res_rd, bus.o_res_we} !== {1'b1, 5'd1, 1'b1})
            begin errors++; $display("FAIL jalr_res: got v=%b rd=%0d we=%b expected 1 1 1", bus.o_res_valid, bus.o_res_rd, bus.o_res_we); end
        step();
        checks++; if ({bus.o_br_valid, bus.o_br_taken, bus.o_br_target} !== {1'b1, 1'b1, 32'h206})
            begin errors++; $display("FAIL jalr_br: got bv=%b tk=%b tgt=%h expected 1 1 206", bus.o_br_valid, bus.o_br_taken, bus.o_br_target); end
        step();
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL jalr_ready: got %b expected 1", bus.o_ready); end
        $display("jalr: target=%h", bus.o_br_target);
    endtask

    task automatic test_illegal();
        issue(32'h0000_007F, 32'h0, 32'd0, 32'd0);
        step();
        issue(enc_i(3, 1, 0, 0, 7'h13), 32'h0, 32'd10, 32'd0);
        checks++; if ({bus.o_illegal, bus.o_alu_valid} !== 2'b10) begin errors++; $display("FAIL ill_pulse: got ill=%b av=%b expected 1 0", bus.o_illegal, bus.o_alu_valid); end
        step();
        bus.i_valid = 1'b0;
        checks++; if ({bus.o_illegal, bus.o_res_valid, bus.o_alu_valid} !== 3'b001) begin errors++; $display("FAIL ill_after: got ill=%b rv=%b av=%b expected 0 0 1", bus.o_illegal, bus.o_res_valid, bus.o_alu_valid); end
        step();
        checks++; if ({bus.o_res_valid, bus.o_res_we} !== 2'b10) begin errors++; $display("FAIL x0_we: got rv=%b we=%b expected 1 0", bus.o_res_valid, bus.o_res_we); end
        $display("illegal/x0: done");
        step();
    endtask

    task automatic test_random();
        localparam int N = 60;
        exp_t        e [N];
        logic [31:0] ins, pc, r1, r2;
        logic [6:0]  opcs [8];
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h0F, 7'h73};
        for (int k = 0; k <= N; k++) begin
            if (k < N) begin
                ins = $urandom;
                ins[6:0] = ($urandom_range(0, 15) == 0) ? 7'h7F : opcs[$urandom_range(0, 7)];
                pc  = $urandom & 32'hFFFF_FFFC;
                r1  = $urandom;
                r2  = $urandom;
                e[k] = model(ins, pc, r1, r2);
                issue(ins, pc, r1, r2);
                checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready: txn %0d got %b expected 1", k, bus.o_ready); end
                $display("txn %0d: instr=%h pc=%h exp op=%h v=%b ill=%b", k, ins, pc, e[k].op, e[k].alu_v, e[k].ill);
            end else begin
                bus.i_valid = 1'b0;
            end
            step();
            if (k < N) begin
                checks++; if ({bus.o_alu_valid, bus.o_illegal} !== {e[k].alu_v, e[k].ill})
                    begin errors++; $display("FAIL rnd_valid: txn %0d got v=%b ill=%b expected %b %b", k, bus.o_alu_valid, bus.o_illegal, e[k].alu_v, e[k].ill); end
                if (e[k].alu_v) begin
                    checks++; if ({bus.o_alu_op, bus.o_alu_a, bus.o_alu_b} !== {e[k].op, e[k].a, e[k].b})
                        begin errors++; $display("FAIL rnd_alu: txn %0d got op=%h a=%h b=%h expected %h %h %h", k, bus.o_alu_op, bus.o_alu_a, bus.o_alu_b, e[k].op, e[k].a, e[k].b); end
                end
            end else begin
                checks++; if (bus.o_alu_valid !== 1'b0) begin errors++; $display("FAIL rnd_idle: got %b expected 0", bus.o_alu_valid); end
            end
            if (k >= 1) begin
                checks++; if (bus.o_res_valid !== e[k-1].alu_v)
                    begin errors++; $display("FAIL rnd_resv: txn %0d got %b expected %b", k - 1, bus.o_res_valid, e[k-1].alu_v); end
                if (e[k-1].alu_v) begin
                    checks++; if ({bus.o_res_rd, bus.o_res_we, bus.o_res_ls} !== {e[k-1].rd, e[k-1].we, e[k-1].ls})
                        begin errors++; $display("FAIL rnd_res: txn %0d got rd=%0d we=%b ls=%b expected %0d %b %b", k - 1, bus.o_res_rd, bus.o_res_we, bus.o_res_ls, e[k-1].rd, e[k-1].we, e[k-1].ls); end
                end
            end
        end
        step();
    endtask

    task automatic test_reset_mid_branch();
        bus.i_zero = 1'b1;
        issue(enc_b(16, 2, 1, 0), 32'h100, 32'd7, 32'd7);
        step();
        bus.i_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checks++; if (all_outs() !== '0) begin errors++; $display("FAIL rstmid_outs: got %h expected 0", all_outs()); end
        step();
        @(negedge clk) rst = 1'b0;
        #1;
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", bus.o_ready); end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if ({bus.o_br_valid, bus.o_br_taken, bus.o_res_valid, bus.o_alu_valid} !== 4'b0000)
                begin errors++; $display("FAIL rstmid_flush: cycle %0d got bv=%b tk=%b rv=%b av=%b expected 0", c, bus.o_br_valid, bus.o_br_taken, bus.o_res_valid, bus.o_alu_valid); end
        end
        bus.i_zero = 1'b0;
        $display("reset_mid_branch: pipeline flushed");
    endtask

    initial begin
        bus.i_valid    = 1'b0;
        bus.i_instr    = '0;
        bus.i_pc       = '0;
        bus.i_rs1_data = '0;
        bus.i_rs2_data = '0;
        bus.i_zero     = 1'b0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_branch(32'd7, 1'b1, 1'b1);
        test_branch(32'd8, 1'b0, 1'b0);
        test_jalr();
        test_illegal();
        test_random();
        test_reset_mid_branch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/ex_decode.md
# ex_decode

Issue stage directly upstream of the registered ALU. It accepts one RV32I instruction per cycle together with its register operands and PC. It decodes the instruction into a 4-bit ALU opcode and two operands, registered straight into the ALU inputs. It carries the writeback and branch sideband through delay registers so that each tag lines up with the ALU's result (one cycle later) and zero flag (two cycles later). It also stalls the front end while a control transfer resolves.

## Interface
- XLEN, 32: datapath width; only 32 is supported.
- BR_STALL, 3: cycles `o_ready` stays low after accepting a branch or jump.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  instruction/operands valid.
- o_ready  out  1  stage can accept; transfer when `i_valid & o_ready`.
- i_instr  in  32  instruction word.
- i_pc  in  32  instruction PC.
- i_rs1_data, i_rs2_data  in  32  register operands, sampled on accept.
- o_alu_a, o_alu_b  out  32  ALU operands (registered).
- o_alu_op  out  4  ALU opcode (registered).
- o_alu_valid  out  1  ALU inputs carry a real operation this cycle.
- o_res_valid  out  1  ALU result is valid this cycle.
- o_res_rd  out  5  destination register.
- o_res_we  out  1  write enable for the result.
- o_res_ls  out  1  result is a load/store address.
- o_br_valid  out  1  branch/jump resolved this cycle.
- o_br_taken  out  1  redirect required.
- o_br_target  out  32  redirect PC.
- o_illegal  out  1  one-cycle pulse for an unsupported opcode.

## Operation
- **ALU op encoding:** ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101, BNE 1111, BLT 1100, BGE 1011, BLTU 1010, BGEU 1001.
- **OP:** op = {funct7[5], funct3}; a = rs1, b = rs2.
- **OP-IMM:** op = {funct3==101 ? funct7[5] : 0, funct3}; a = rs1, b = imm_i (sign-extended).
- **LUI:** a = 0, b = imm_u, ADD.
- **AUIPC:** a = pc, b = imm_u, ADD.
- **LOAD/STORE:** a = rs1, b = imm_i or imm_s, ADD.
  - `o_res_ls` = 1.
  - `o_res_we` = 1 only for LOAD (address result; the memory stage owns the data).
- **BRANCH:** a = rs1, b = rs2.
  - funct3 000 (BEQ) maps to SUB; 001, 100, 101, 110, 111 map to BNE, BLT, BGE, BLTU, BGEU respectively.
  - Taken iff ALU `o_zero` = 1.
  - Target = pc + imm_b, computed locally.
  - `o_res_we` = 0.
- **JAL / JALR:** a = pc, b = 4, ADD; `o_res_we` = 1.
  - Target for JAL = pc + imm_j.
  - Target for JALR = (rs1 + imm_i) & ~1.
  - `o_br_taken` = 1 unconditionally.
- **FENCE:** accepted as a NOP; `o_alu_valid` = 0, no illegal pulse.
- **Illegal:** SYSTEM and unknown opcodes are accepted and raise `o_illegal`; `o_alu_valid` = 0.
- **rd = x0:** forces `o_res_we` = 0.
- **Idle cycles:** operand and op registers hold their last value; only the valid bits deassert.
- **FSM:**
  - States: RUN, BWAIT.
  - RUN: `o_ready` = 1.
  - Accepting a branch or jump loads a down-counter with BR_STALL and enters BWAIT.
  - BWAIT: `o_ready` = 0; return to RUN when the counter reaches 0.
- **`o_br_taken` sampling:** equals `is_jump | i_zero`, where i_zero is the ALU zero flag, an input tapped in the cycle `o_br_valid` asserts.

## Timing
- Instruction accepted in cycle T:
  - T+1: `o_alu_*`, `o_alu_valid`, `o_illegal`.
  - T+2: `o_res_valid` with rd/we/ls.
  - T+3: `o_br_valid`, `o_br_taken`, `o_br_target` (branch/jump only).
- Non-control instructions sustain one per cycle.
- After a branch or jump accepted at T, `o_ready` is low at T+1..T+3 and high at T+4; the front end presents the correct-path instruction at T+4.
- All valid/pulse outputs are single-cycle per instruction.
- **Reset** (asynchronous, immediate):
  - All outputs become 0 and the state returns to RUN.
  - The sideband pipeline is cleared, so no `o_res_valid` or `o_br_valid` fires for work in flight.
  - `o_ready` = 1 in the first cycle after release.

## Structure
- Shared package `rv32i_pkg` holds:
  - opcode constants;
  - ALU op localparams (ALU_ADD … ALU_BGEU);
  - FSM state encoding.
- Sub-module `imm_gen` (combinational) produces imm_i/s/b/u/j from the instruction.
- Decode, operand registers, sideband delay line and FSM stay in `ex_decode`.

## Test plan
- **ADDI x5,x1,-1**, rs1 = 5, accept at T:
  - T+1: op 0000, a = 5, b = 0xFFFFFFFF.
  - T+2: `o_res_valid` = 1, rd = 5, we = 1.
- **SRA x3,x4,x6** then **SUB** back to back: op 1101 then 1000 on consecutive cycles; `o_ready` stays 1.
- **BEQ**, rs1 = rs2 = 7, pc = 0x100, imm = +16:
  - op 1000; `o_ready` = 0 at T+1..T+3.
  - T+3: `o_br_valid` = 1 with i_zero = 1, giving taken = 1, target = 0x110.
  - Repeat with rs2 = 8 and i_zero = 0: taken = 0.
- **JALR x1**, rs1 = 0x203, imm = 4, pc = 0x40:
  - a = 0x40, b = 4, we = 1, rd = 1.
  - T+3: taken = 1, target = 0x206.
- **Opcode 0x7F:** `o_illegal` pulse at T+1, `o_alu_valid` = 0; **ADDI rd = x0:** we = 0.
- **Reset at T+2 of a BEQ:**
  - All outputs are 0 immediately.
  - No `o_br_valid` afterwards.
  - `o_ready` = 1 the first cycle after release.
